alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result bundle between a requester and alu_seq
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             ovf;
    logic             dz;

    modport master (
        output start, op, a, b,
        input  busy, done, lo, hi, zero, ovf, dz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, lo, hi, zero, ovf, dz
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic/arith ops, iterative MULU/DIVU
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             load_seq, step, finish_seq, finish_single;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, mq_q, m_q;
    logic             is_div_q;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic             zero_q, ovf_q, dz_q;

    // FSM next-state and control strobes
    always_comb begin
        state_d       = state_q;
        load_seq      = 1'b0;
        step          = 1'b0;
        finish_seq    = 1'b0;
        finish_single = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    if (bus.op == 4'd7 || bus.op == 4'd8) begin
                        state_d  = CALC;
                        load_seq = 1'b1;
                    end else begin
                        state_d       = DONE;
                        finish_single = 1'b1;
                    end
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d    = DONE;
                    finish_seq = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Single-cycle results
    logic [WIDTH-1:0] s_lo, neg_b;
    logic             s_ovf;
    always_comb begin
        s_lo  = '0;
        s_ovf = 1'b0;
        neg_b = ~bus.b + 1'b1;
        case (bus.op)
            4'd0: begin
                s_lo  = bus.a + bus.b;
                s_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (s_lo[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd1: begin
                s_lo  = bus.a - bus.b;
                s_ovf = (bus.a[WIDTH-1] == neg_b[WIDTH-1]) && (s_lo[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd2: s_lo = bus.a & bus.b;
            4'd3: s_lo = bus.a | bus.b;
            4'd4: s_lo = ~(bus.a | bus.b);
            4'd5: s_lo = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'd6: s_lo = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: s_lo = '0;
        endcase
    end

    // Iterative step: acc holds partial product high / running remainder,
    // mq holds multiplier bits / dividend bits turning into quotient bits.
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0] acc_n, mq_n;
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, m_q} : '0);
        div_sh   = {acc_q, mq_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_q};
        if (is_div_q) begin
            acc_n = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            mq_n  = {mq_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            acc_n = mul_sum[WIDTH:1];
            mq_n  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            if (finish_single) begin
                lo_q   <= s_lo;
                hi_q   <= '0;
                zero_q <= (s_lo == '0);
                ovf_q  <= s_ovf;
                dz_q   <= 1'b0;
            end
            if (load_seq) begin
                cnt_q    <= '0;
                acc_q    <= '0;
                is_div_q <= (bus.op == 4'd8);
                mq_q     <= (bus.op == 4'd8) ? bus.a : bus.b;
                m_q      <= (bus.op == 4'd8) ? bus.b : bus.a;
            end
            if (step) begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= acc_n;
                mq_q  <= mq_n;
            end
            // A zero divisor falls out naturally: every step "subtracts", giving all-ones / a
            if (finish_seq) begin
                lo_q   <= mq_n;
                hi_q   <= acc_n;
                zero_q <= (mq_n == '0);
                ovf_q  <= 1'b0;
                dz_q   <= is_div_q && (m_q == '0);
            end
        end
    end

    assign bus.busy = (state_q == CALC);
    assign bus.done = (state_q == DONE);
    assign bus.lo   = lo_q;
    assign bus.hi   = hi_q;
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
    assign bus.dz   = dz_q;
endmodule
